// File: rtl/alu_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package alu_md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  localparam int MD_DEFAULT_WIDTH = 32;

  // Width of the iteration counter, which must be able to hold WIDTH itself.
  function automatic int md_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // MULT and DIV treat their operands as two's complement.
  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's complement negation: used both to take operand
// magnitudes and to restore result signs.
module md_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/alu_md.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then fixes signs in a final cycle.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = MD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = md_cnt_width(WIDTH);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_aOrig;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;
  logic               r_divZero;
  logic               r_busy;
  logic               r_done;

  logic               w_opSigned;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH+1:0]   w_addA;
  logic [WIDTH+1:0]   w_addB;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_accNext;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  assign w_opSigned = md_is_signed(md_op_e'(op));

  md_abs_neg #(.W(WIDTH)) u_absA (
    .i_val(a), .i_neg(w_opSigned & a[WIDTH-1]), .o_val(w_magA)
  );

  md_abs_neg #(.W(WIDTH)) u_absB (
    .i_val(b), .i_neg(w_opSigned & b[WIDTH-1]), .o_val(w_magB)
  );

  // Shared adder/subtractor: add for shift-add multiply, trial subtract for
  // restoring divide. The extra top bit is the borrow of the trial subtract.
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_addA     = r_isDiv ? {1'b0, w_remShift} : {2'b00, r_acc[2*WIDTH-1:WIDTH]};
  assign w_addB     = {2'b00, r_opnd};
  assign w_sum      = r_isDiv ? (w_addA - w_addB) : (w_addA + w_addB);

  // One radix-2 step of the accumulator/remainder shift register.
  always_comb begin
    w_accNext = r_acc;
    if (r_isDiv) begin
      if (!w_sum[WIDTH+1])
        w_accNext = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        w_accNext = {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      if (r_acc[0])
        w_accNext = {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
      else
        w_accNext = {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};
    end
  end

  md_abs_neg #(.W(2*WIDTH)) u_prodFix (
    .i_val(r_acc), .i_neg(r_negQ), .o_val(w_prodFix)
  );

  md_abs_neg #(.W(WIDTH)) u_quoFix (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_negQ), .o_val(w_quoFix)
  );

  md_abs_neg #(.W(WIDTH)) u_remFix (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_negR), .o_val(w_remFix)
  );

  // Final HI/LO selection; divide by zero bypasses sign correction entirely.
  always_comb begin
    w_fixHi = w_prodFix[2*WIDTH-1:WIDTH];
    w_fixLo = w_prodFix[WIDTH-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        w_fixHi = r_aOrig;
        w_fixLo = '1;
      end else begin
        w_fixHi = w_remFix;
        w_fixLo = w_quoFix;
      end
    end
  end

  // Control FSM with registered busy/done, plus HI/LO and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_aOrig   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      if (cancel) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_isDiv   <= op[1];
              r_negQ    <= w_opSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_negR    <= w_opSigned & a[WIDTH-1];
              r_divZero <= (b == '0);
              r_aOrig   <= a;
              if (op[1]) begin
                r_opnd <= w_magB;
                r_acc  <= {{WIDTH{1'b0}}, w_magA};
              end else begin
                r_opnd <= w_magA;
                r_acc  <= {{WIDTH{1'b0}}, w_magB};
              end
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
          RUN: begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= FIX;
          end
          FIX: begin
            r_hi    <= w_fixHi;
            r_lo    <= w_fixLo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: table of vectors run back to back through
// a result scoreboard, followed by hand-written cancel/ignore/reset sequences.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   total = 0;
  int   bad = 0;
  exp_t sbQueue[$];
  vec_t vecs[$];

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      MD_MULT:  return sx * sy;
      MD_MULTU: return ux * uy;
      MD_DIV: begin
        if (y == '0) return {x, 32'hFFFFFFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == '0) return {x, 32'hFFFFFFFF};
        return {(ux % uy) >> 0, 32'h0} | {32'h0, (ux / uy) & 64'hFFFFFFFF};
      end
    endcase
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbQueue.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput($sformatf("result%0d", e.idx), {hi, lo}, {e.hi, e.lo});
      end
    end
  end

  // Wait (bounded) for done; counts edges and busy samples taken #1 after each edge.
  task automatic waitDone(input string nm, output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCnt++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done", nm);
      if (sbQueue.size() != 0) void'(sbQueue.pop_front());
    end
  endtask

  // Issue one operation (scoreboarded) and check acceptance, busy span and latency.
  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    int lat, bc;
    op = v.op;
    a = v.a;
    b = v.b;
    start = 1'b1;
    e.hi = v.expHi;
    e.lo = v.expLo;
    e.idx = idx;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput($sformatf("accept%0d", idx), {63'h0, busy}, 64'h1);
    waitDone($sformatf("op%0d", idx), lat, bc);
    checkOutput($sformatf("latency%0d", idx), 64'(lat), 64'(LAT));
    checkOutput($sformatf("busycycles%0d", idx), 64'(bc + 1), 64'(LAT));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc;
    bit sawDone;
    logic [2*W-1:0] r;
    vec_t v;

    vecs.push_back('{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    vecs.push_back('{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});
    vecs.push_back('{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
    vecs.push_back('{MD_MULT,  32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000});
    for (int i = 0; i < 6; i++) begin
      v.op = 2'(i % 4);
      v.a = $urandom;
      v.b = (i == 5) ? 32'(($urandom_range(1, 50))) : $urandom;
      r = model(v.op, v.a, v.b);
      v.expHi = r[2*W-1:W];
      v.expLo = r[W-1:0];
      vecs.push_back(v);
    end

    // Reset state.
    #12;
    checkOutput("reset_hi", {32'h0, hi}, 64'h0);
    checkOutput("reset_lo", {32'h0, lo}, 64'h0);
    checkOutput("reset_busy_done", {62'h0, busy, done}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table vectors, each started in the done cycle of the previous one.
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // cancel and start together in IDLE: nothing starts.
    start = 1'b1;
    cancel = 1'b1;
    op = MD_MULT;
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
    checkOutput("cancel_beats_start", {63'h0, busy}, 64'h0);

    // MTHI in IDLE.
    hi_we = 1'b1;
    wdata = 32'h00001234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checkOutput("mthi_idle", {32'h0, hi}, 64'h1234);

    // MULT with a coinciding MTLO, then cancelled at cycle 10.
    op = MD_MULT;
    a = 32'h5;
    b = 32'h6;
    start = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000ABCD;
    @(posedge clk);
    #1;
    start = 1'b0;
    lo_we = 1'b0;
    checkOutput("mtlo_with_start", {32'h0, lo}, 64'hABCD);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checkOutput("cancel_busy_drop", {63'h0, busy}, 64'h0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("cancel_no_done", {63'h0, sawDone}, 64'h0);
    checkOutput("cancel_hi_kept", {hi, lo}, {32'h1234, 32'hABCD});

    // start and hi_we while busy are ignored.
    v = '{MD_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142};
    begin
      exp_t e;
      e.hi = v.expHi;
      e.lo = v.expLo;
      e.idx = 100;
      sbQueue.push_back(e);
    end
    op = v.op;
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = MD_MULTU;
    a = 32'h3;
    b = 32'h3;
    start = 1'b1;
    hi_we = 1'b1;
    wdata = 32'h0000DEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    waitDone("busy_ignore", lat, bc);
    checkOutput("busy_ignore_latency", 64'(lat + 6), 64'(LAT));
    @(posedge clk);
    #1;
    checkOutput("busy_ignore_not_queued", {63'h0, busy}, 64'h0);
    checkOutput("busy_ignore_hi", {32'h0, hi}, 64'h6);

    // Asynchronous reset in the middle of RUN.
    op = MD_MULTU;
    a = 32'hFFFFFFFF;
    b = 32'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_hilo", {hi, lo}, 64'h0);
    checkOutput("async_reset_busy_done", {62'h0, busy, done}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", {62'h0, busy, done}, 64'h0);
    checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
